// File: rtl/platform_level_interrupt_controller__gateway.sv
`default_nettype none
// ============================================================================
// Module   : platform_level_interrupt_controller__gateway
// Brief    : Per-source interrupt gateway bank. Turns raw level- or
//            edge-signalled device lines into pending bits (ip) and
//            terminates the claim/complete handshake. Source i has ID i+1.
//            ID 0 is reserved and means "no interrupt".
//            Optional feature macro: PLIC_GATEWAY_EDGE_COUNT_EN.
//            It adds an 8-bit saturating per-source counter that remembers
//            edges which arrive while the source is busy.
// Revision : 1.0 - initial release
// ============================================================================
module platform_level_interrupt_controller__gateway #(
    parameter int NUM_SOURCES = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SOURCES-1:0] src,
    input  logic [NUM_SOURCES-1:0] edge_sel,
    input  logic                   claim_valid,
    input  logic [9:0]             claim_id,
    input  logic                   complete_valid,
    input  logic [9:0]             complete_id,
    output logic [NUM_SOURCES-1:0] ip,
    output logic [NUM_SOURCES-1:0] claimed
);

    // One-hot per-source gateway state.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'b001,
        ST_PENDING = 3'b010,
        ST_CLAIMED = 3'b100
    } gw_state_t;

    // Previous value of every raw line, used for rising-edge detection.
    logic [NUM_SOURCES-1:0] src_q;

    // Sample the raw lines once per cycle for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q <= '0;
        end else begin
            src_q <= src;
        end
    end

    for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_src
        // IDs outside 1..NUM_SOURCES never match any source, so they are
        // ignored without any explicit range check.
        localparam logic [9:0] SRC_ID = 10'(i + 1);

        gw_state_t state;
        logic      pend_r;
        logic      clm_r;
        logic      claim_hit;
        logic      complete_hit;
        logic      rise;
        logic      req;

        assign claim_hit    = claim_valid    && (claim_id    == SRC_ID);
        assign complete_hit = complete_valid && (complete_id == SRC_ID);
        assign rise         = src[i] & ~src_q[i];

`ifdef PLIC_GATEWAY_EDGE_COUNT_EN
        logic [7:0] cnt;
        logic       busy;

        // An edge only counts when it cannot act right away: the source is
        // pending, or claimed without its complete arriving this cycle (a
        // complete-cycle edge re-pends the source directly instead).
        assign busy = (state == ST_PENDING) ||
                      ((state == ST_CLAIMED) && !complete_hit);

        assign req = edge_sel[i] ? (rise | (cnt != 8'd0)) : src[i];

        // Saturating edge counter; cleared while the source is level mode.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= 8'd0;
            end else if (!edge_sel[i]) begin
                cnt <= 8'd0;
            end else if ((state == ST_CLAIMED) && complete_hit && !rise &&
                         (cnt != 8'd0)) begin
                cnt <= cnt - 8'd1;
            end else if (rise && busy && (cnt != 8'hFF)) begin
                cnt <= cnt + 8'd1;
            end
        end
`else
        assign req = edge_sel[i] ? rise : src[i];
`endif

        // Gateway state machine with registered ip / claimed outputs.
        always_ff @(posedge clk) begin
            if (rst) begin
                state  <= ST_IDLE;
                pend_r <= 1'b0;
                clm_r  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (req) begin
                            state  <= ST_PENDING;
                            pend_r <= 1'b1;
                            clm_r  <= 1'b0;
                        end
                    end
                    ST_PENDING: begin
                        // No retraction: a pending source waits for its claim
                        // even if a level line drops.
                        if (claim_hit) begin
                            state  <= ST_CLAIMED;
                            pend_r <= 1'b0;
                            clm_r  <= 1'b1;
                        end
                    end
                    ST_CLAIMED: begin
                        if (complete_hit) begin
                            if (req) begin
                                state  <= ST_PENDING;
                                pend_r <= 1'b1;
                                clm_r  <= 1'b0;
                            end else begin
                                state  <= ST_IDLE;
                                pend_r <= 1'b0;
                                clm_r  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        pend_r <= 1'b0;
                        clm_r  <= 1'b0;
                    end
                endcase
            end
        end

        assign ip[i]      = pend_r;
        assign claimed[i] = clm_r;
    end

endmodule
`default_nettype wire
